// File: rtl/button_bounce_gen.sv
// Bouncing active-low pushbutton stimulus: bouncy press, clean hold, bouncy release.
// Bounce gaps are drawn from a free-running 16-bit Galois LFSR.
module button_bounce_gen #(
  parameter int unsigned CW          = 32,
  parameter int unsigned GAP_BITS    = 10,
  parameter int unsigned MAX_TOGGLES = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] hold_cycles,
  input  logic [3:0]    toggles,
  output logic          button_out,
  output logic          busy,
  output logic          done,
  output logic [1:0]    phase
);

  localparam int unsigned GW   = GAP_BITS + 1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_BOUNCE   = 2'd1,
    HOLD           = 2'd2,
    RELEASE_BOUNCE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [GW-1:0] gap_q, gap_d, gap_new;
  logic [4:0]    rem_q, rem_d;
  logic [3:0]    tog_q, tog_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_d, busy_d, done_d;
  logic [3:0]    tog_clamp;
  logic [CW-1:0] hold_clamp;

  assign tog_clamp  = (32'(toggles) > MAX_TOGGLES) ? 4'(MAX_TOGGLES) : toggles;
  assign hold_clamp = (hold_cycles == '0) ? CW'(1) : hold_cycles;
  assign gap_new    = GW'(lfsr_q[GAP_BITS-1:0]) + GW'(1);
  assign phase      = state_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0000);
    gap_d   = gap_q;
    rem_d   = rem_q;
    tog_d   = tog_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    btn_d   = button_out;
    busy_d  = busy;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        btn_d = 1'b1;
        if (start) begin
          tog_d   = tog_clamp;
          hold_d  = hold_clamp;
          btn_d   = 1'b0;
          busy_d  = 1'b1;
          rem_d   = {tog_clamp, 1'b0};
          gap_d   = gap_new;
          state_d = PRESS_BOUNCE;
        end
      end
      PRESS_BOUNCE, RELEASE_BOUNCE: begin
        if (gap_q > GW'(1)) begin
          gap_d = gap_q - GW'(1);
        end else if (rem_q != 5'd0) begin
          btn_d = ~button_out;
          rem_d = rem_q - 5'd1;
          gap_d = gap_new;
        end else if (state_q == PRESS_BOUNCE) begin
          cnt_d   = hold_q;
          state_d = HOLD;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          btn_d   = 1'b1;
          rem_d   = {tog_q, 1'b0};
          gap_d   = gap_new;
          state_d = RELEASE_BOUNCE;
        end
      end
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      gap_q      <= GW'(1);
      rem_q      <= 5'd0;
      tog_q      <= 4'd0;
      hold_q     <= CW'(1);
      cnt_q      <= CW'(1);
      button_out <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      gap_q      <= gap_d;
      rem_q      <= rem_d;
      tog_q      <= tog_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      button_out <= btn_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
